// File: rtl/stochastic_number_generator.sv
// -----------------------------------------------------------------------------
// stochastic_number_generator
//
// Purpose
//   Binary-to-stochastic converter. A DATA_WIDTH-bit unsigned value is
//   accepted in IDLE and turned into STREAM_LEN serial bits. The ones-density
//   of the stream is value/(2^DATA_WIDTH-1). Each bit is the result of
//   comparing a maximal-length Galois LFSR sample against the stored value.
//   sc_bit/sc_valid are meant to feed a downstream shift register's
//   data_in/shift pins directly.
//
// Parameters
//   DATA_WIDTH  width of the value and of the LFSR, legal range 4..16
//   STREAM_LEN  number of bits emitted per conversion, >= 1
//   SEED        LFSR reset/reseed value; a zero seed is replaced by 1
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   in_valid  in   value presented for conversion
//   in_ready  out  high only in IDLE
//   value     in   unsigned input, captured on accept
//   hold      in   stall while RUN (freezes LFSR, beat counter and state)
//   sc_bit    out  stochastic bit, meaningful when sc_valid is high
//   sc_valid  out  one beat of the stream
//   busy      out  high in RUN and DONE
//   done      out  one-cycle pulse in the cycle after the last beat
//
// Configuration macro
//   SNG_RESEED_EN  defined:   the LFSR is reloaded with SEED on every accept,
//                             so streams are repeatable and period-aligned.
//                  undefined: the LFSR free-runs across conversions and keeps
//                             stepping in IDLE and DONE, so consecutive
//                             streams are decorrelated. Only rst reloads SEED.
// -----------------------------------------------------------------------------
module stochastic_number_generator #(
    parameter int DATA_WIDTH = 8,
    parameter int STREAM_LEN = 255,
    parameter int SEED       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] value,
    input  logic                  hold,
    output logic                  sc_bit,
    output logic                  sc_valid,
    output logic                  busy,
    output logic                  done
);

    // Maximal-length feedback masks for a right-shifting Galois LFSR.
    function automatic logic [15:0] galoisTaps(input int width);
        case (width)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0E08;
            13:      return 16'h1C80;
            14:      return 16'h3802;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

    localparam int                  CW         = (STREAM_LEN < 1) ? 1 : $clog2(STREAM_LEN + 1);
    localparam logic [DATA_WIDTH-1:0] TAPS     = DATA_WIDTH'(galoisTaps(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] SEED_RAW = DATA_WIDTH'(SEED);
    // An all-zero LFSR never leaves zero, so a zero seed is replaced by 1.
    localparam logic [DATA_WIDTH-1:0] SEED_EFF = (SEED_RAW == '0) ? DATA_WIDTH'(1) : SEED_RAW;
    localparam logic [CW-1:0]         LAST_CNT = CW'(STREAM_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] lfsr_q, lfsr_d;
    logic [DATA_WIDTH-1:0] value_q, value_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  accept;

    // One Galois step: shift right and fold the taps in when a one falls out.
    // Non-zero states cycle through all 2^W-1 values, which is what makes the
    // ones count of a full-period stream equal the value exactly.
    function automatic logic [DATA_WIDTH-1:0] lfsrStep(input logic [DATA_WIDTH-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : '0);
    endfunction

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign accept   = in_valid && in_ready;

    // A beat is any RUN cycle not stalled by hold; the bit is gated by the
    // beat so the shift register never sees a stray one.
    assign sc_valid = (state_q == RUN) && !hold;
    assign sc_bit   = (lfsr_q <= value_q) && sc_valid;

    // Next-state logic: accept in IDLE, one beat per unstalled RUN cycle,
    // single DONE cycle back to IDLE.
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        count_d = count_q;
`ifdef SNG_RESEED_EN
        lfsr_d  = lfsr_q;
`else
        // Free-running: the generator steps every cycle except a stalled RUN
        // cycle, so back-to-back streams start from different states.
        lfsr_d  = lfsrStep(lfsr_q);
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    value_d = value;
                    count_d = '0;
`ifdef SNG_RESEED_EN
                    lfsr_d  = SEED_EFF;
`endif
                end
            end

            RUN: begin
                if (sc_valid) begin
                    lfsr_d  = lfsrStep(lfsr_q);
                    count_d = count_q + CW'(1);
                    if (count_q == LAST_CNT) begin
                        state_d = DONE;
                    end
                end else begin
                    lfsr_d = lfsr_q;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any stream in progress without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            lfsr_q  <= SEED_EFF;
            value_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            value_q <= value_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_stochastic_number_generator.sv
// -----------------------------------------------------------------------------
// tb_stochastic_number_generator
//
// Self-checking bench for stochastic_number_generator (DATA_WIDTH=8,
// STREAM_LEN=255, SEED=1). A reference model tracks the control state and the
// LFSR; on every accept it pushes the whole expected bit stream into a queue,
// and the monitor pops one entry per sc_valid beat. Stream-level totals are
// compared against fixed expectations (beat count, ones count, RUN length).
// -----------------------------------------------------------------------------
module tb_stochastic_number_generator;

    localparam int W    = 8;
    localparam int LEN  = 255;
    localparam int SEED = 1;

`ifdef SNG_RESEED_EN
    localparam bit RESEED = 1'b1;
`else
    localparam bit RESEED = 1'b0;
`endif

    logic         clk      = 1'b0;
    logic         rst      = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] value    = '0;
    logic         hold     = 1'b0;
    logic         in_ready;
    logic         sc_bit;
    logic         sc_valid;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;

    stochastic_number_generator #(
        .DATA_WIDTH (W),
        .STREAM_LEN (LEN),
        .SEED       (SEED)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .value    (value),
        .hold     (hold),
        .sc_bit   (sc_bit),
        .sc_valid (sc_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    // Reference model: standard x^8+x^6+x^5+x^4+1 Galois register.
    function automatic logic [W-1:0] modelStep(input logic [W-1:0] s);
        return {1'b0, s[W-1:1]} ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

    typedef enum int {M_IDLE, M_RUN, M_DONE} mstate_t;
    mstate_t      mState = M_IDLE;
    logic [W-1:0] mLfsr  = 8'd1;
    int           mCnt   = 0;
    bit           expQ[$];

    // Model updates on the same edges as the DUT; inputs change #1 after
    // posedge so they are stable here.
    always @(posedge clk or negedge rst) begin
        logic [W-1:0] start;
        logic [W-1:0] s;
        if (!rst) begin
            mState = M_IDLE;
            mLfsr  = 8'd1;
            mCnt   = 0;
            expQ.delete();
        end else begin
            case (mState)
                M_IDLE: begin
                    if (in_valid) begin
                        start = RESEED ? 8'd1 : modelStep(mLfsr);
                        s = start;
                        for (int k = 0; k < LEN; k++) begin
                            expQ.push_back(s <= value);
                            s = modelStep(s);
                        end
                        mLfsr  = start;
                        mCnt   = 0;
                        mState = M_RUN;
                    end else if (!RESEED) begin
                        mLfsr = modelStep(mLfsr);
                    end
                end
                M_RUN: begin
                    if (!hold) begin
                        mLfsr = modelStep(mLfsr);
                        mCnt++;
                        if (mCnt == LEN) mState = M_DONE;
                    end
                end
                default: begin
                    if (!RESEED) mLfsr = modelStep(mLfsr);
                    mState = M_IDLE;
                end
            endcase
        end
    end

    // Monitor bookkeeping for stream-level checks.
    int             beats       = 0;
    int             ones        = 0;
    int             runCycles   = 0;
    int             lastBeats   = 0;
    int             lastOnes    = 0;
    int             lastRun     = 0;
    int             streamsDone = 0;
    int             gapCount    = 0;
    int             lastGap     = 0;
    logic           prevBusy    = 1'b0;
    logic [LEN-1:0] curBits     = '0;
    logic [LEN-1:0] lastBits    = '0;

    // Sample away from the active edge: control outputs against the model,
    // each beat against the scoreboard queue.
    always @(negedge clk) begin
        checkOutput("in_ready", in_ready, mState == M_IDLE);
        checkOutput("busy", busy, mState != M_IDLE);
        checkOutput("done", done, mState == M_DONE);
        checkOutput("sc_valid", sc_valid, (mState == M_RUN) && !hold);
        if (!sc_valid) checkOutput("sc_bit_idle", sc_bit, 0);
        if (!rst) begin
            beats     = 0;
            ones      = 0;
            runCycles = 0;
            gapCount  = 0;
        end else begin
            if (sc_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("beat_unexpected", 1, 0);
                end else begin
                    checkOutput("sc_bit", sc_bit, expQ.pop_front());
                end
                if (beats < LEN) curBits[beats] = sc_bit;
                beats++;
                ones += int'(sc_bit);
            end
            if (busy && !done) runCycles++;
            if (!busy) gapCount++;
            if (busy && !prevBusy) begin
                lastGap  = gapCount;
                gapCount = 0;
            end
            if (done) begin
                lastBeats = beats;
                lastOnes  = ones;
                lastRun   = runCycles;
                lastBits  = curBits;
                beats     = 0;
                ones      = 0;
                runCycles = 0;
                streamsDone++;
            end
        end
        prevBusy = busy;
    end

    // Bounded wait until the monitor has seen the requested number of streams.
    task automatic waitStreams(input int target, input string tag);
        int guard = 0;
        while (streamsDone < target && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (streamsDone < target) checkOutput({tag, "_timeout"}, 0, 1);
    endtask

    // Runs one conversion: present v for one accepted cycle, optionally stall
    // for holdLen cycles once holdAt beats have gone by, then wait for done.
    task automatic applyStimulus(input logic [W-1:0] v, input int holdAt, input int holdLen, input string tag);
        int guard = 0;
        int target;
        target = streamsDone + 1;
        @(posedge clk); #1;
        while (!in_ready && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b1;
        value    = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (holdAt >= 0) begin
            guard = 0;
            while (beats < holdAt && guard < 1000) begin
                @(posedge clk); #1;
                guard++;
            end
            hold = 1'b1;
            repeat (holdLen) @(posedge clk);
            #1 hold = 1'b0;
        end
        waitStreams(target, tag);
    endtask

    logic [LEN-1:0] refBits;
    logic [LEN-1:0] firstBits;

    initial begin
        int guard;
        int target;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_sc_valid", sc_valid, 0);
        rst = 1'b1;

        // value=0x80: 255 beats, 128 ones, 255 RUN cycles.
        applyStimulus(8'h80, -1, 0, "s80");
        checkOutput("s80_beats", lastBeats, 255);
        checkOutput("s80_ones", lastOnes, 128);
        checkOutput("s80_run", lastRun, 255);
        refBits = lastBits;

        // Extremes.
        applyStimulus(8'h00, -1, 0, "s00");
        checkOutput("s00_beats", lastBeats, 255);
        checkOutput("s00_ones", lastOnes, 0);
        applyStimulus(8'hFF, -1, 0, "sFF");
        checkOutput("sFF_beats", lastBeats, 255);
        checkOutput("sFF_ones", lastOnes, 255);
        applyStimulus(8'h13, -1, 0, "s13");
        checkOutput("s13_ones", lastOnes, 8'h13);

        // Ten-cycle stall at beat 100.
        applyStimulus(8'h80, 100, 10, "hold");
        checkOutput("hold_beats", lastBeats, 255);
        checkOutput("hold_ones", lastOnes, 128);
        checkOutput("hold_run", lastRun, 265);
        if (RESEED) checkOutput("hold_same_seq", lastBits == refBits, 1);

        // hold while idle must not start or disturb anything.
        @(posedge clk); #1;
        hold = 1'b1;
        repeat (4) @(posedge clk);
        #1 hold = 1'b0;

        // in_valid held through two streams of 0x80.
        target = streamsDone + 1;
        in_valid = 1'b1;
        value    = 8'h80;
        waitStreams(target, "b2b_first");
        firstBits = lastBits;
        checkOutput("b2b1_beats", lastBeats, 255);
        checkOutput("b2b1_ones", lastOnes, 128);
        guard = 0;
        while (!busy && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        waitStreams(target + 1, "b2b_second");
        checkOutput("b2b2_beats", lastBeats, 255);
        checkOutput("b2b2_ones", lastOnes, 128);
        checkOutput("b2b_gap", lastGap, 1);
        checkOutput("b2b_same_seq", firstBits == lastBits, RESEED);

        // Reset in the middle of a stream.
        @(posedge clk); #1;
        in_valid = 1'b1;
        value    = 8'h80;
        @(posedge clk); #1;
        in_valid = 1'b0;
        guard = 0;
        while (beats < 50 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("pre_rst_busy", busy, 1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_in_ready", in_ready, 1);
        checkOutput("mid_rst_sc_valid", sc_valid, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        applyStimulus(8'h40, -1, 0, "post_rst");
        checkOutput("post_rst_beats", lastBeats, 255);
        checkOutput("post_rst_ones", lastOnes, 64);

        repeat (3) @(posedge clk);
        checkOutput("queue_empty", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
